// File: rtl/store_pkg.sv
// Shared types and helpers for the store read-modify-write sequencer.
package store_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Alignment check only; the reserved size code is rejected separately.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational merge of new store data into the low bits of the read word.
module store_merge
  import store_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [31:0] mdr_i,
  input  logic [31:0] b_i,
  output logic [31:0] merged_o
);

  // Select how many low bits of the read word are replaced.
  always_comb begin
    merged_o = b_i;
    case (size_i)
      SZ_BYTE: merged_o = {mdr_i[31:8], b_i[7:0]};
      SZ_HALF: merged_o = {mdr_i[31:16], b_i[15:0]};
      SZ_WORD: merged_o = b_i;
      default: merged_o = b_i;
    endcase
  end

endmodule

// File: rtl/store_rmw_sequencer.sv
// Multicycle store sequencer: sub-word stores read-modify-write, word stores
// write directly; busy/done/error let the control FSM stall around it.
module store_rmw_sequencer
  import store_pkg::*;
#(
  parameter int MEM_READ_LATENCY = 1,
  parameter int ADDR_W           = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        store_size,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       b_in,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] LAT_C = 3'(MEM_READ_LATENCY);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       b_q;
  logic [31:0]       mdr_q;
  logic [31:0]       mdr_d;
  logic [2:0]        cnt_q;
  logic              rd_q, wr_q, busy_q, done_q, error_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged_s;
  logic              reject_s;
  logic              capture_s;

  assign capture_s = (state_q == WAIT) && (cnt_q == 3'd1);
  assign mdr_d     = capture_s ? mem_rdata : mdr_q;
  assign reject_s  = (store_size == 2'b11) || is_misaligned(store_size, address[1:0]);

  // Merge uses the word being captured this cycle so WRITE sees final data.
  store_merge u_merge (
    .size_i   (size_q),
    .mdr_i    (mdr_d),
    .b_i      (b_q),
    .merged_o (merged_s)
  );

  // Sequencer FSM; strobes are set on entry to the state that owns them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= 2'b00;
      b_q     <= 32'd0;
      mdr_q   <= 32'd0;
      cnt_q   <= 3'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q <= address;
            size_q <= store_size;
            b_q    <= b_in;
            busy_q <= 1'b1;
            if (reject_s) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else if (store_size == SZ_WORD) begin
              state_q <= WRITE;
              wr_q    <= 1'b1;
              wdata_q <= b_in;
              error_q <= 1'b0;
            end else begin
              state_q <= READ;
              rd_q    <= 1'b1;
              error_q <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        READ: begin
          cnt_q   <= LAT_C;
          state_q <= WAIT;
        end
        WAIT: begin
          if (capture_s) begin
            mdr_q   <= mdr_d;
            wdata_q <= merged_s;
            wr_q    <= 1'b1;
            state_q <= WRITE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        WRITE: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          error_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          error_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
